sparse_col_scheduler: RTL and testbench
=======================================

SPARSE_COL_SCHEDULER -- requirements
Module: sparse_col_scheduler

Interface
REQ-001 SHALL have parameter NUM_COLS, default 64: number of weight columns tracked.
REQ-002 SHALL have parameter IDX_SENTINEL, default 6'h3F: compressed pointer value that marks a zero column.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sparse_mode, input, 1 bit: 1 = issue occupied columns only; 0 = issue all columns.
REQ-006 SHALL have ports wr_compressed (input, 1 bit), wr_comp_idx (input, 6 bits) and wr_comp_ptr (input, 6 bits): snoop of the compressed-weight write stream.
REQ-007 SHALL have port clear_mask, input, 1 bit: clears column occupancy.
REQ-008 SHALL have port start, input, 1 bit: level request to run one schedule pass.
REQ-009 SHALL have ports col_valid (output, 1 bit), col_idx (output, 6 bits) and col_ready (input, 1 bit): column-issue handshake to the PE array.
REQ-010 SHALL have port done, output, 1 bit: pass complete.
REQ-011 SHALL have ports busy (output, 1 bit) and wr_dropped (output, 1 bit, sticky).
REQ-012 SHALL have ports mon_active_columns (output, 7 bits) and mon_column_sparsity (output, 16 bits, units of 0.01%).

Function
REQ-013 SHALL, on wr_compressed=1 and wr_comp_ptr!=IDX_SENTINEL, set mask[wr_comp_idx]; a sentinel write SHALL NOT clear a bit.
REQ-014 SHALL, on clear_mask=1, zero the mask; if a setting write occurs in the same cycle, the result is only that write's bit set.
REQ-015 SHALL register mon_active_columns = popcount(mask) and mon_column_sparsity = floor((NUM_COLS-active)*10000/NUM_COLS), both one cycle after any mask change.
REQ-016 SHALL implement states IDLE, ISSUE, DONE.
REQ-017 SHALL, in IDLE with start=1, go to ISSUE on the next edge, or to DONE if sparse_mode=1 and the mask is zero.
REQ-018 SHALL, in ISSUE, present col_valid=1 with col_idx = the lowest eligible column at or above the scan pointer; eligible means set in the mask (sparse) or any column (dense).
REQ-019 SHALL advance the scan pointer only on col_valid&&col_ready, and SHALL hold col_idx stable while col_ready=0.
REQ-020 SHALL issue at most one column per cycle in ascending order with no bubbles while col_ready=1.
REQ-021 SHALL go to DONE on the handshake of the last eligible column, with no wrap-around.
REQ-022 SHALL assert done only in DONE, and SHALL return to IDLE when start=0.
REQ-023 SHALL hold busy=1 in ISSUE and DONE.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL, while busy, freeze the mask, ignore wr_compressed and clear_mask, and set wr_dropped for any ignored write; wr_dropped clears only on reset.
REQ-026 SHALL sample sparse_mode at IDLE→ISSUE and hold that value for the whole pass.

Reset
REQ-027 SHALL, on reset=0, asynchronously force state=IDLE, mask=0, scan pointer=0, col_valid=0, col_idx=0, done=0, busy=0, wr_dropped=0, mon_active_columns=0 and mon_column_sparsity=10000.
REQ-028 SHALL, on reset asserted mid-pass, abandon the pass with no further col_valid.

Configuration
REQ-029 SHALL, with SCHED_STALL_CNT_EN defined, add output mon_stall_cycles (32 bits), incremented each cycle col_valid=1 and col_ready=0, cleared on IDLE→ISSUE, saturating.
REQ-030 SHALL, without SCHED_STALL_CNT_EN, keep the port tied to 0 and contain no counter logic.

Structure
REQ-031 SHALL take the state enum, IDX_SENTINEL, NUM_COLS and the sparsity scale (10000) from shared package bnn_sched_pkg.
REQ-032 SHALL contain one sub-module, col_prio_enc: a combinational 64-bit find-first-set at or above a start index, with outputs found and idx.

Verification
REQ-033 SHALL cover: sparse, bits at col%4==0 loaded, start → col_idx 0,4,…,60 (16 handshakes); active=16; sparsity=7500; done after the 16th handshake.
REQ-034 SHALL cover: sparse, cols 0,10,20,30,40,50 loaded → 6 issues; active=6; sparsity=9062.
REQ-035 SHALL cover: sparse, empty mask, start → done=1 two edges after start, col_valid never 1.
REQ-036 SHALL cover: col_ready=0 for 3 cycles while col_idx=4 → col_idx held at 4, mon_stall_cycles=3 (when SCHED_STALL_CNT_EN is defined), next issue is 8.
REQ-037 SHALL cover: dense mode, mask 0 → 64 issues 0..63, done.
REQ-038 SHALL cover: write during ISSUE → mask unchanged, wr_dropped=1.
REQ-039 SHALL cover: reset low at the 5th issue → outputs at reset values, and a new start restarts from column 0.

Source files
------------

// File: rtl/bnn_sched_pkg.sv
// Shared types, constants and helpers for the sparse column scheduler.
package bnn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    localparam int         SCHED_NUM_COLS     = 64;
    localparam logic [5:0] SCHED_IDX_SENTINEL = 6'h3F;
    localparam int         SPARSITY_SCALE     = 10000;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < 64; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

    // Empty-column fraction in hundredths of a percent, rounded down.
    function automatic logic [15:0] sparsity_bp(input logic [6:0] active, input int num_cols);
        logic [31:0] t;
        t = ((32'(num_cols) - {25'd0, active}) * 32'(SPARSITY_SCALE)) / 32'(num_cols);
        return t[15:0];
    endfunction

endpackage

// File: rtl/sparse_col_scheduler_col_prio_enc.sv
// col_prio_enc: combinational find-first-set over a 64-bit vector, searching
// upward from a start index.
module col_prio_enc (
    input  logic [63:0] vec,
    input  logic [5:0]  start,
    output logic        found,
    output logic [5:0]  idx
);

    // Scan downward so the lowest qualifying bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i] && (i >= int'(start))) begin
                found = 1'b1;
                idx   = 6'(i);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/sparse_col_scheduler.sv
// sparse_col_scheduler: tracks occupied weight columns and issues them to the PE
// array. Optional stall counter enabled by defining SCHED_STALL_CNT_EN.
module sparse_col_scheduler
    import bnn_sched_pkg::*;
#(
    parameter int         NUM_COLS     = SCHED_NUM_COLS,
    parameter logic [5:0] IDX_SENTINEL = SCHED_IDX_SENTINEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sparse_mode,
    input  logic        wr_compressed,
    input  logic [5:0]  wr_comp_idx,
    input  logic [5:0]  wr_comp_ptr,
    input  logic        clear_mask,
    input  logic        start,
    output logic        col_valid,
    output logic [5:0]  col_idx,
    input  logic        col_ready,
    output logic        done,
    output logic        busy,
    output logic        wr_dropped,
    output logic [6:0]  mon_active_columns,
    output logic [15:0] mon_column_sparsity,
    output logic [31:0] mon_stall_cycles
);

    sched_state_e state_q, state_d;
    logic [63:0]  mask_q, mask_d;
    logic [5:0]   col_idx_q, col_idx_d;
    logic         col_valid_q, col_valid_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         mode_q, mode_d;
    logic         wr_dropped_q, wr_dropped_d;
    logic [6:0]   active_q, active_d;
    logic [15:0]  sparsity_q, sparsity_d;

    logic         busy_s;
    logic [63:0]  set_vec_s;
    logic [63:0]  dense_vec_s;
    logic [63:0]  enc_vec_s;
    logic [5:0]   enc_start_s;
    logic         enc_found_s;
    logic [5:0]   enc_idx_s;

    col_prio_enc u_prio (
        .vec   (enc_vec_s),
        .start (enc_start_s),
        .found (enc_found_s),
        .idx   (enc_idx_s)
    );

    // Mask update; frozen while a pass is running, with dropped writes flagged.
    always_comb begin
        busy_s       = (state_q != ST_IDLE);
        set_vec_s    = (wr_compressed && (wr_comp_ptr != IDX_SENTINEL)) ? (64'd1 << wr_comp_idx) : 64'd0;
        mask_d       = mask_q;
        wr_dropped_d = wr_dropped_q;
        if (busy_s) begin
            wr_dropped_d = wr_dropped_q | wr_compressed;
        end else begin
            mask_d = (clear_mask ? 64'd0 : mask_q) | set_vec_s;
        end
    end

    // Search vector and base: from column 0 when starting, past the current column otherwise.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            dense_vec_s[i] = (i < NUM_COLS) ? 1'b1 : 1'b0;
        end
        enc_vec_s   = ((busy_s ? mode_q : sparse_mode) ? mask_q : dense_vec_s);
        enc_start_s = busy_s ? (col_idx_q + 6'd1) : 6'd0;
    end

    // Schedule FSM next-state and registered-output values.
    always_comb begin
        state_d     = state_q;
        col_valid_d = col_valid_q;
        col_idx_d   = col_idx_q;
        done_d      = done_q;
        busy_d      = busy_q;
        mode_d      = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = sparse_mode;
                    busy_d = 1'b1;
                    if (enc_found_s) begin
                        state_d     = ST_ISSUE;
                        col_valid_d = 1'b1;
                        col_idx_d   = enc_idx_s;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (col_valid_q && col_ready) begin
                    // Column 63 is always the last; the wrapped search base must not restart at 0.
                    if ((col_idx_q != 6'd63) && enc_found_s) begin
                        col_idx_d = enc_idx_s;
                    end else begin
                        state_d     = ST_DONE;
                        col_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                col_valid_d = 1'b0;
                done_d      = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Occupancy monitors lag the mask by one cycle.
    always_comb begin
        active_d   = popcount64(mask_q);
        sparsity_d = sparsity_bp(active_d, NUM_COLS);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mask_q       <= 64'd0;
            col_idx_q    <= 6'd0;
            col_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            mode_q       <= 1'b0;
            wr_dropped_q <= 1'b0;
            active_q     <= 7'd0;
            sparsity_q   <= 16'd10000;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            col_idx_q    <= col_idx_d;
            col_valid_q  <= col_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            mode_q       <= mode_d;
            wr_dropped_q <= wr_dropped_d;
            active_q     <= active_d;
            sparsity_q   <= sparsity_d;
        end
    end

`ifdef SCHED_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Stall counter restarts on each issuing pass and saturates.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start && enc_found_s) begin
            stall_d = 32'd0;
        end else if (col_valid_q && !col_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign mon_stall_cycles = stall_q;
`else
    assign mon_stall_cycles = 32'd0;
`endif

    assign col_valid           = col_valid_q;
    assign col_idx             = col_idx_q;
    assign done                = done_q;
    assign busy                = busy_q;
    assign wr_dropped          = wr_dropped_q;
    assign mon_active_columns  = active_q;
    assign mon_column_sparsity = sparsity_q;

endmodule

// File: tb/tb_sparse_col_scheduler.sv
// Bench for sparse_col_scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized passes.
module tb_sparse_col_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sparse_mode = 1'b0;
    logic        wr_compressed = 1'b0;
    logic [5:0]  wr_comp_idx = 6'd0;
    logic [5:0]  wr_comp_ptr = 6'd0;
    logic        clear_mask = 1'b0;
    logic        start = 1'b0;
    logic        col_ready = 1'b0;
    logic        col_valid, done, busy, wr_dropped;
    logic [5:0]  col_idx;
    logic [6:0]  mon_active_columns;
    logic [15:0] mon_column_sparsity;
    logic [31:0] mon_stall_cycles;

    sparse_col_scheduler dut (
        .clk(clk), .reset(reset), .sparse_mode(sparse_mode),
        .wr_compressed(wr_compressed), .wr_comp_idx(wr_comp_idx), .wr_comp_ptr(wr_comp_ptr),
        .clear_mask(clear_mask), .start(start),
        .col_valid(col_valid), .col_idx(col_idx), .col_ready(col_ready),
        .done(done), .busy(busy), .wr_dropped(wr_dropped),
        .mon_active_columns(mon_active_columns), .mon_column_sparsity(mon_column_sparsity),
        .mon_stall_cycles(mon_stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    endtask

    // Reference model: the pending-issue list of the current pass plus occupancy.
    logic [63:0] m_mask = 64'd0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_drop = 1'b0;
    int          m_q[$];
    int          m_stall = 0;
    int          e_active = 0;
    int          e_sparsity = 10000;
    int          issued[$];
    bit          cv_seen = 1'b0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_mask = 64'd0; m_busy = 1'b0; m_done = 1'b0; m_drop = 1'b0;
            m_q.delete(); m_stall = 0; e_active = 0; e_sparsity = 10000;
        end else begin
            e_active   = $countones(m_mask);
            e_sparsity = (64 - e_active) * 10000 / 64;
            if (!m_busy) begin
                if (start) begin
                    m_q.delete();
                    for (int c = 0; c < 64; c++)
                        if (!sparse_mode || m_mask[c]) m_q.push_back(c);
                    m_busy = 1'b1;
                    if (m_q.size() == 0) m_done = 1'b1;
                    else m_stall = 0;
                end
                if (clear_mask) m_mask = 64'd0;
                if (wr_compressed && wr_comp_ptr != 6'h3F) m_mask[wr_comp_idx] = 1'b1;
            end else begin
                if (wr_compressed) m_drop = 1'b1;
                if (m_done) begin
                    if (!start) begin m_busy = 1'b0; m_done = 1'b0; end
                end else if (col_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_done = 1'b1;
                end else begin
                    m_stall++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus handshake logging.
    initial forever begin
        bit exp_valid;
        @(negedge clk);
        exp_valid = m_busy && !m_done;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("col_valid", col_valid, exp_valid);
        if (exp_valid) chk("col_idx", col_idx, m_q[0]);
        chk("wr_dropped", wr_dropped, m_drop);
        chk("mon_active", mon_active_columns, e_active);
        chk("mon_sparsity", mon_column_sparsity, e_sparsity);
`ifdef SCHED_STALL_CNT_EN
        chk("mon_stall", mon_stall_cycles, m_stall);
`else
        chk("mon_stall_tied", mon_stall_cycles, 0);
`endif
        if (reset && col_valid && col_ready) issued.push_back(int'(col_idx));
        if (col_valid) cv_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mask(input logic [63:0] m);
        // Clear and write column 0 in the same cycle.
        clear_mask = 1'b1; wr_compressed = 1'b1; wr_comp_idx = 6'd0;
        wr_comp_ptr = m[0] ? 6'd5 : 6'h3F;
        tick();
        clear_mask = 1'b0;
        for (int i = 1; i < 64; i++) begin
            wr_comp_idx = 6'(i);
            wr_comp_ptr = m[i] ? 6'($urandom_range(0, 62)) : 6'h3F;
            tick();
        end
        wr_compressed = 1'b0;
        tick(); tick();
    endtask

    task automatic finish_pass(input string nm, input bit rnd);
        bit fin;
        fin = done;
        for (int k = 0; k < 400 && !fin; k++) begin
            tick();
            if (done) fin = 1'b1;
            else if (rnd) begin
                col_ready     = 1'($urandom_range(0, 1));
                wr_compressed = ($urandom_range(0, 7) == 0);
                wr_comp_idx   = 6'($urandom);
                wr_comp_ptr   = 6'($urandom);
                sparse_mode   = 1'($urandom_range(0, 1));
            end
        end
        chk(nm, fin, 1);
        start = 1'b0; wr_compressed = 1'b0; col_ready = 1'b1;
        tick();
    endtask

    task automatic run_pass(input bit sp, input bit rnd);
        issued.delete();
        sparse_mode = sp;
        col_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start       = 1'b1;
        finish_pass("pass_done", rnd);
    endtask

    logic [63:0] m4, m10, rm;
    int          exp_cols[$];
    bit          hit;

    initial begin
        for (int i = 0; i < 64; i++) begin
            m4[i]  = (i % 4 == 0);
            m10[i] = (i % 10 == 0) && (i <= 50);
        end
        tick(); tick();
        chk("rst_col_valid", col_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sparsity", mon_column_sparsity, 10000);
        reset = 1'b1;
        tick();

        // Every fourth column, sparse.
        load_mask(m4);
        chk("m4_active", mon_active_columns, 16);
        chk("m4_sparsity", mon_column_sparsity, 7500);
        run_pass(1'b1, 1'b0);
        chk("m4_count", issued.size(), 16);
        for (int j = 0; j < issued.size(); j++) chk("m4_col", issued[j], 4 * j);

        // Columns 0,10,..,50.
        load_mask(m10);
        chk("m10_active", mon_active_columns, 6);
        chk("m10_sparsity", mon_column_sparsity, 9062);
        run_pass(1'b1, 1'b0);
        chk("m10_count", issued.size(), 6);
        for (int j = 0; j < issued.size(); j++) chk("m10_col", issued[j], 10 * j);

        // Empty mask, sparse: straight to done.
        load_mask(64'd0);
        sparse_mode = 1'b1; col_ready = 1'b1; cv_seen = 1'b0; start = 1'b1;
        tick(); tick();
        chk("empty_done", done, 1);
        chk("empty_no_valid", cv_seen, 0);
        start = 1'b0;
        tick();

        // Dense with an empty mask issues every column.
        run_pass(1'b0, 1'b0);
        chk("dense_count", issued.size(), 64);
        for (int j = 0; j < issued.size(); j++) chk("dense_col", issued[j], j);

        // Backpressure at column 4.
        load_mask(m4);
        issued.delete(); sparse_mode = 1'b1; col_ready = 1'b1; start = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            tick();
            if (col_valid && col_idx == 6'd4) hit = 1'b1;
        end
        chk("stall_reach4", hit, 1);
        col_ready = 1'b0;
        tick(); tick(); tick();
        chk("stall_hold", col_idx, 4);
`ifdef SCHED_STALL_CNT_EN
        chk("stall_cnt", mon_stall_cycles, 3);
`endif
        col_ready = 1'b1;
        tick();
        chk("stall_next", col_idx, 8);
        finish_pass("stall_done", 1'b0);

        // Write while issuing is dropped.
        sparse_mode = 1'b0; col_ready = 1'b0; start = 1'b1;
        tick(); tick();
        wr_compressed = 1'b1; wr_comp_idx = 6'd1; wr_comp_ptr = 6'd2;
        tick();
        wr_compressed = 1'b0;
        tick(); tick();
        chk("drop_flag", wr_dropped, 1);
        chk("drop_active", mon_active_columns, 16);
        col_ready = 1'b1;
        finish_pass("drop_done", 1'b0);

        // Reset on the fifth issue, then a fresh pass.
        sparse_mode = 1'b0; col_ready = 1'b1; start = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            tick();
            if (col_valid && col_idx == 6'd4) hit = 1'b1;
        end
        chk("rst5_reach", hit, 1);
        reset = 1'b0;
        #1;
        chk("rst5_valid", col_valid, 0);
        chk("rst5_idx", col_idx, 0);
        chk("rst5_busy", busy, 0);
        chk("rst5_done", done, 0);
        chk("rst5_dropped", wr_dropped, 0);
        chk("rst5_active", mon_active_columns, 0);
        chk("rst5_sparsity", mon_column_sparsity, 10000);
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        run_pass(1'b0, 1'b0);
        chk("rst5_count", issued.size(), 64);
        if (issued.size() > 0) chk("rst5_first", issued[0], 0);

        // Randomized masks, modes, backpressure and dropped writes.
        for (int r = 0; r < 10; r++) begin
            bit sp;
            rm = {$urandom, $urandom};
            if (r % 3 == 1) rm = rm & {$urandom, $urandom} & {$urandom, $urandom};
            if (r == 7) rm = 64'd0;
            sp = 1'($urandom_range(0, 1));
            load_mask(rm);
            exp_cols.delete();
            for (int c = 0; c < 64; c++) if (!sp || rm[c]) exp_cols.push_back(c);
            run_pass(sp, 1'b1);
            chk("rnd_count", issued.size(), exp_cols.size());
            for (int j = 0; j < issued.size() && j < exp_cols.size(); j++)
                chk("rnd_col", issued[j], exp_cols[j]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
